mc_main_fsm: RTL and testbench

Multicycle main controller for the RISC-V core. It sequences each instruction through Fetch, Decode and execute states and drives every datapath mux select and write enable. It produces the 2-bit `alu_op` that the ALU decoder turns into the ALU control code, so it sits directly upstream of that decoder. It replaces the single-cycle main decoder when the core moves to the shared-memory multicycle datapath.

---
 rtl/mc_main_fsm.sv | 206 ++++++++++++++++++++
 tb/tb_mc_main_fsm.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mc_main_fsm.sv
// -----------------------------------------------------------------------------
// mc_main_fsm -- multicycle main controller for the RV32I subset
// (lw, sw, R-type, I-type ALU, jal, beq).
//
// Steps each instruction through FETCH, DECODE and its execute states. It
// drives every datapath mux select and write enable. It also produces the
// 2-bit alu_op that feeds the ALU decoder.
//
// Ports
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   op_i[6:0]      opcode from the instruction register
//   zero_i         ALU zero flag
//   pc_write_o     PC enable = (zero & branch) | pc_update
//   adr_src_o      memory address: 0 = PC, 1 = ALUOut
//   mem_write_o    data memory write enable
//   ir_write_o     instruction / old-PC register enable
//   result_src_o   result mux: 00 ALUOut, 01 Data, 10 ALU result
//   alu_src_a_o    ALU A: 00 PC, 01 OldPC, 10 rs1
//   alu_src_b_o    ALU B: 00 rs2, 01 ImmExt, 10 constant 4
//   alu_op_o       00 add, 01 sub, 10 funct-decoded
//   reg_write_o    register file write enable
//   imm_src_o      immediate format: 00 I, 01 S, 10 B, 11 J
//   illegal_op_o   one-cycle pulse in DECODE for an unsupported opcode
//   state_dbg_o    current state encoding
// -----------------------------------------------------------------------------
module mc_main_fsm (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [6:0] op_i,
   input  logic       zero_i,
   output logic       pc_write_o,
   output logic       adr_src_o,
   output logic       mem_write_o,
   output logic       ir_write_o,
   output logic [1:0] result_src_o,
   output logic [1:0] alu_src_a_o,
   output logic [1:0] alu_src_b_o,
   output logic [1:0] alu_op_o,
   output logic       reg_write_o,
   output logic [1:0] imm_src_o,
   output logic       illegal_op_o,
   output logic [3:0] state_dbg_o
);

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_ALUWB    = 4'd7,
      S_EXECUTEI = 4'd8,
      S_JAL      = 4'd9,
      S_BEQ      = 4'd10
   } state_e;

   typedef struct packed {
      logic       adr_src;
      logic       mem_write;
      logic       ir_write;
      logic [1:0] result_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       reg_write;
      logic       branch;
      logic       pc_update;
   } ctrl_t;

   // Control word for a given state; unlisted fields stay 0.
   function automatic ctrl_t decode_ctrl(input state_e s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.ir_write   = 1'b1;
            c.alu_src_b  = 2'b10;
            c.result_src = 2'b10;
            c.pc_update  = 1'b1;
         end
         S_DECODE: begin
            c.alu_src_a = 2'b01;
            c.alu_src_b = 2'b01;
         end
         S_MEMADR: begin
            c.alu_src_a = 2'b10;
            c.alu_src_b = 2'b01;
         end
         S_MEMREAD:  c.adr_src = 1'b1;
         S_MEMWB: begin
            c.result_src = 2'b01;
            c.reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            c.adr_src   = 1'b1;
            c.mem_write = 1'b1;
         end
         S_EXECUTER: begin
            c.alu_src_a = 2'b10;
            c.alu_op    = 2'b10;
         end
         S_EXECUTEI: begin
            c.alu_src_a = 2'b10;
            c.alu_src_b = 2'b01;
            c.alu_op    = 2'b10;
         end
         S_ALUWB:    c.reg_write = 1'b1;
         S_JAL: begin
            c.alu_src_a = 2'b01;
            c.alu_src_b = 2'b10;
            c.pc_update = 1'b1;
         end
         S_BEQ: begin
            c.alu_src_a = 2'b10;
            c.alu_op    = 2'b01;
            c.branch    = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   state_e state_q, state_d;
   ctrl_t  ctrl_q, ctrl_d;
   logic   op_known;

   always_comb begin
      op_known = (op_i == OP_LW) || (op_i == OP_SW) || (op_i == OP_R) ||
                 (op_i == OP_I) || (op_i == OP_JAL) || (op_i == OP_BEQ);
   end

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (op_i)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECUTER;
               OP_I:         state_d = S_EXECUTEI;
               OP_JAL:       state_d = S_JAL;
               OP_BEQ:       state_d = S_BEQ;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR:   state_d = (op_i == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  state_d = S_MEMWB;
         S_EXECUTER: state_d = S_ALUWB;
         S_EXECUTEI: state_d = S_ALUWB;
         S_JAL:      state_d = S_ALUWB;
         // MEMWB, MEMWRITE, ALUWB, BEQ and the unused codes 11-15 all
         // return to FETCH.
         default:    state_d = S_FETCH;
      endcase
   end

   // The control word is computed for the next state, so it is ready in
   // the register on the same edge as the state itself.
   always_comb ctrl_d = decode_ctrl(state_d);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_FETCH;
         ctrl_q  <= decode_ctrl(S_FETCH);
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
      end
   end

   // Write enables are qualified with rst_ni. The registers already hold
   // the FETCH word during reset, but the enables must drop combinationally
   // the moment reset asserts.
   assign pc_write_o   = rst_ni & ((zero_i & ctrl_q.branch) | ctrl_q.pc_update);
   assign ir_write_o   = rst_ni & ctrl_q.ir_write;
   assign reg_write_o  = rst_ni & ctrl_q.reg_write;
   assign mem_write_o  = rst_ni & ctrl_q.mem_write;
   assign illegal_op_o = rst_ni & (state_q == S_DECODE) & ~op_known;

   assign adr_src_o    = ctrl_q.adr_src;
   assign result_src_o = ctrl_q.result_src;
   assign alu_src_a_o  = ctrl_q.alu_src_a;
   assign alu_src_b_o  = ctrl_q.alu_src_b;
   assign alu_op_o     = ctrl_q.alu_op;
   assign state_dbg_o  = state_q;

   always_comb begin
      case (op_i)
         OP_SW:   imm_src_o = 2'b01;
         OP_BEQ:  imm_src_o = 2'b10;
         OP_JAL:  imm_src_o = 2'b11;
         default: imm_src_o = 2'b00;
      endcase
   end

endmodule

// File: tb/tb_mc_main_fsm.sv
// -----------------------------------------------------------------------------
// tb_mc_main_fsm -- scoreboard bench for mc_main_fsm.
// The driver applies inputs 1 time unit after each rising edge. It pushes
// the expected output vector for that cycle, built from hand-written state
// sequences and the per-state output table. The monitor pops and compares
// on every falling edge, or on an explicit sample event.
// -----------------------------------------------------------------------------
module tb_mc_main_fsm;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] op;
   logic       zero;
   logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op;
   logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;
   logic [3:0] state_dbg;

   always #5 clk = ~clk;

   mc_main_fsm dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .op_i         (op),
      .zero_i       (zero),
      .pc_write_o   (pc_write),
      .adr_src_o    (adr_src),
      .mem_write_o  (mem_write),
      .ir_write_o   (ir_write),
      .result_src_o (result_src),
      .alu_src_a_o  (alu_src_a),
      .alu_src_b_o  (alu_src_b),
      .alu_op_o     (alu_op),
      .reg_write_o  (reg_write),
      .imm_src_o    (imm_src),
      .illegal_op_o (illegal_op),
      .state_dbg_o  (state_dbg)
   );

   typedef struct packed {
      logic [3:0] state;
      logic       pc_write;
      logic       adr_src;
      logic       mem_write;
      logic       ir_write;
      logic [1:0] result_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       reg_write;
      logic [1:0] imm_src;
      logic       illegal_op;
   } exp_t;

   typedef struct {
      string name;
      exp_t  v;
   } rec_t;

   rec_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   event sample_ev;

   localparam logic [6:0] LW  = 7'b0000011;
   localparam logic [6:0] SW  = 7'b0100011;
   localparam logic [6:0] RT  = 7'b0110011;
   localparam logic [6:0] IT  = 7'b0010011;
   localparam logic [6:0] JAL = 7'b1101111;
   localparam logic [6:0] BEQ = 7'b1100011;
   localparam logic [6:0] BAD = 7'b1111111;

   // Hand-written output table per state.
   function automatic exp_t expect_of(input logic [3:0] st, input logic [6:0] o,
                                      input logic z, input logic in_rst,
                                      input logic ill);
      exp_t e;
      logic branch, pc_upd;
      e = '0;
      branch = 1'b0;
      pc_upd = 1'b0;
      e.state = st;
      case (st)
         4'd0:  begin e.ir_write = 1; e.alu_src_b = 2'b10; e.result_src = 2'b10; pc_upd = 1; end
         4'd1:  begin e.alu_src_a = 2'b01; e.alu_src_b = 2'b01; end
         4'd2:  begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; end
         4'd3:  e.adr_src = 1;
         4'd4:  begin e.result_src = 2'b01; e.reg_write = 1; end
         4'd5:  begin e.adr_src = 1; e.mem_write = 1; end
         4'd6:  begin e.alu_src_a = 2'b10; e.alu_op = 2'b10; end
         4'd7:  e.reg_write = 1;
         4'd8:  begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; e.alu_op = 2'b10; end
         4'd9:  begin e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; pc_upd = 1; end
         4'd10: begin e.alu_src_a = 2'b10; e.alu_op = 2'b01; branch = 1; end
         default: e = '0;
      endcase
      e.pc_write   = (z & branch) | pc_upd;
      e.illegal_op = (st == 4'd1) & ill;
      e.imm_src    = (o == SW) ? 2'b01 : (o == BEQ) ? 2'b10 : (o == JAL) ? 2'b11 : 2'b00;
      if (in_rst) begin
         e.pc_write   = 0;
         e.ir_write   = 0;
         e.reg_write  = 0;
         e.mem_write  = 0;
         e.illegal_op = 0;
      end
      return e;
   endfunction

   // Monitor: compares one queued expectation per falling edge or sample event.
   always begin
      rec_t r;
      exp_t got;
      @(negedge clk or sample_ev);
      if (q.size() > 0) begin
         r   = q.pop_front();
         got = '{state_dbg, pc_write, adr_src, mem_write, ir_write, result_src,
                 alu_src_a, alu_src_b, alu_op, reg_write, imm_src, illegal_op};
         n_checks++;
         if (got !== r.v) begin
            n_fail++;
            $display("FAIL %s: got %05h required %05h", r.name, got, r.v);
         end else begin
            $display("ok   %s: state=%0d outputs=%05h", r.name, got.state, got);
         end
      end
   end

   task automatic cyc(input string nm, input logic [3:0] st, input logic [6:0] o,
                      input logic z, input logic in_rst, input logic ill);
      rec_t r;
      @(posedge clk);
      #1;
      rst_n = ~in_rst;
      op    = o;
      zero  = z;
      r.name = nm;
      r.v    = expect_of(st, o, z, in_rst, ill);
      q.push_back(r);
   endtask

   // seq holds n state codes, first state in the most significant used nibble.
   task automatic run_instr(input string nm, input logic [6:0] o, input logic z,
                            input int n, input logic [19:0] seq, input logic ill);
      for (int i = 0; i < n; i++)
         cyc($sformatf("%s c%0d", nm, i), seq[(n-1-i)*4 +: 4], o, z, 1'b0, ill);
   endtask

   initial begin
      rst_n = 1'b0;
      op    = 7'd0;
      zero  = 1'b0;
      for (int i = 0; i < 3; i++) cyc($sformatf("reset c%0d", i), 4'd0, 7'd0, 1'b0, 1'b1, 1'b0);

      run_instr("lw",     LW,  1'b0, 5, {4'd0, 4'd1, 4'd2, 4'd3, 4'd4}, 1'b0);
      run_instr("sw",     SW,  1'b0, 4, {4'd0, 4'd1, 4'd2, 4'd5}, 1'b0);
      run_instr("rtype",  RT,  1'b0, 4, {4'd0, 4'd1, 4'd6, 4'd7}, 1'b0);
      run_instr("itype",  IT,  1'b1, 4, {4'd0, 4'd1, 4'd8, 4'd7}, 1'b0);
      run_instr("beq_z1", BEQ, 1'b1, 3, {4'd0, 4'd1, 4'd10}, 1'b0);
      run_instr("beq_z0", BEQ, 1'b0, 3, {4'd0, 4'd1, 4'd10}, 1'b0);
      run_instr("jal",    JAL, 1'b0, 4, {4'd0, 4'd1, 4'd9, 4'd7}, 1'b0);
      run_instr("illegal", BAD, 1'b0, 2, {4'd0, 4'd1}, 1'b1);
      run_instr("sw_rst", SW,  1'b0, 4, {4'd0, 4'd1, 4'd2, 4'd5}, 1'b0);

      // Assert reset partway through MEMWRITE: state and mem_write must drop
      // without waiting for a clock edge.
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      begin
         rec_t r;
         r.name = "async_rst";
         r.v    = expect_of(4'd0, SW, 1'b0, 1'b1, 1'b0);
         q.push_back(r);
      end
      #1;
      -> sample_ev;

      cyc("reset2", 4'd0, SW, 1'b0, 1'b1, 1'b0);
      run_instr("lw2",   LW, 1'b0, 5, {4'd0, 4'd1, 4'd2, 4'd3, 4'd4}, 1'b0);
      run_instr("final", LW, 1'b0, 1, {16'd0, 4'd0}, 1'b0);

      @(negedge clk);
      #1;
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d queued required 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
